// File: rtl/core_pkg.sv
// core_pkg: shared RV32I core constants for writeback-source select and load encodings.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;
    localparam logic [1:0] WB_SRC_IMM = 2'b11;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/load_align.sv
// load_align: extracts a byte/half/word from an aligned memory word with sign/zero extension and flags misalignment.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        is_b, is_h, sx;
    always_comb begin
        b          = word[{offset, 3'b000} +: 8];
        h          = word[{offset[1], 4'b0000} +: 16];
        is_b       = (funct3 == F3_LB) || (funct3 == F3_LBU);
        is_h       = (funct3 == F3_LH) || (funct3 == F3_LHU);
        sx         = !funct3[2];
        // any funct3 that is neither byte nor half falls through to a full word
        data       = is_b ? {{(XLEN-8){sx & b[7]}}, b} :
                     is_h ? {{(XLEN-16){sx & h[15]}}, h} : word;
        misaligned = is_h ? offset[0] : (!is_b && offset != 2'b00);
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback select, driving the register-file write port,
// forwarding tag/data, misaligned-load flag and retired-instruction counter.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_mem,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [3:0]           control_word_mem,
    input  logic [2:0]           funct3_mem,
    input  logic [4:0]           rd_mem,
    input  logic [XLEN-1:0]      alu_result_mem,
    input  logic [XLEN-1:0]      pc_plus_4_mem,
    input  logic [XLEN-1:0]      imm_mem,
    input  logic [XLEN-1:0]      mem_data_out,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 valid_wb,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 load_misalign,
    output logic [INSTRET_W-1:0] instret
);
    logic            rf_wb, take, mis, la_mis, unused_pc_src;
    logic [1:0]      wb_src;
    logic [XLEN-1:0] load_data, wdata;

    assign rf_wb         = control_word_mem[3];
    assign wb_src        = control_word_mem[2:1];
    assign unused_pc_src = control_word_mem[0];

    load_align #(.XLEN(XLEN)) u_align (
        .word       (mem_data_out),
        .offset     (alu_result_mem[1:0]),
        .funct3     (funct3_mem),
        .data       (load_data),
        .misaligned (la_mis)
    );

    always_comb begin
        take  = valid_mem && !stall && !flush;
        mis   = (wb_src == WB_SRC_MEM) && la_mis;
        wdata = (wb_src == WB_SRC_ALU) ? alu_result_mem :
                (wb_src == WB_SRC_MEM) ? load_data :
                (wb_src == WB_SRC_PC4) ? pc_plus_4_mem : imm_mem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_wb      <= 1'b0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            load_misalign <= 1'b0;
            instret       <= '0;
        end else begin
            // counts the instruction leaving WB on this edge
            instret       <= instret + INSTRET_W'(valid_wb);
            valid_wb      <= take;
            rf_we         <= take && rf_wb && (rd_mem != 5'd0) && !mis;
            load_misalign <= take && mis;
            if (take) begin
                rf_waddr <= rd_mem;
                rf_wdata <= wdata;
            end
        end
    end

    assign fwd_rd   = rf_we ? rf_waddr : 5'd0;
    assign fwd_data = rf_wdata;
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary and writeback stage of the 5-stage RV32I core; sits directly downstream of the memory stage.
- Captures the 4-bit MEM control word, destination register, ALU result, PC+4, immediate and raw data-memory word.
- Performs load byte/half extraction with sign/zero extension and selects writeback data.
- Drives the register-file write port, a forwarding copy, a misaligned-load flag and the retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- INSTRET_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_mem  in  1  MEM stage holds a real instruction this cycle.
- stall  in  1  MEM stage is holding its instruction; WB must not capture it.
- flush  in  1  kill the instruction currently in MEM.
- control_word_mem  in  4  {rf_wb, wb_src[1:0], pc_src_mem}.
- funct3_mem  in  3  load width/sign (RV32I encoding).
- rd_mem  in  5  destination register.
- alu_result_mem  in  XLEN  ALU result; also the load address (bits [1:0] = byte offset).
- pc_plus_4_mem  in  XLEN  link value for JAL/JALR.
- imm_mem  in  XLEN  immediate (LUI).
- mem_data_out  in  XLEN  raw aligned word from data memory, valid combinationally in the MEM cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- valid_wb  out  1  WB holds a real instruction.
- fwd_rd  out  5  forwarding tag (= rf_waddr when rf_we, else 0).
- fwd_data  out  XLEN  forwarding data (= rf_wdata).
- load_misalign  out  1  registered; high for one WB cycle on a misaligned load.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous): valid_wb=0, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_rd=0, load_misalign=0, instret=0. Reset asserted mid-operation discards the held instruction immediately.
- Latency: exactly one cycle. Inputs are sampled at the rising edge; all outputs are registered, except fwd_rd/fwd_data, which are combinational copies of registered values.
- Capture rule at each edge: if flush or stall or !valid_mem, load a bubble (valid_wb=0, rf_we=0, load_misalign=0); data registers may hold stale values. Otherwise capture the instruction. flush and stall together behave as a bubble.
- wb_src encoding: 00 ALU result, 01 load data, 10 PC+4, 11 immediate.
- Load extraction (wb_src=01), offset = alu_result_mem[1:0]:
  - LB/LBU: byte at offset, sign/zero extended.
  - LH/LHU: halfword at offset[1]*16, sign/zero extended.
  - LW: full word.
- Misalignment: halfword with offset[0]=1, or word with offset!=0. The instruction retires, but rf_we=0 and load_misalign=1 for that WB cycle.
- Unsupported funct3 on a load (011, 110, 111): treated as LW.
- rf_we = valid_wb & rf_wb & (rd!=0) & !misaligned. Writes to x0 are never issued.
- pc_src_mem is not used for writeback; it is ignored here.
- instret: increments by 1 on each edge where valid_wb=1 (counts instructions leaving WB, misaligned loads included); wraps from all-ones to 0.
- No back-pressure: WB always completes in one cycle.

Decomposition:
- Shared package core_pkg holds:
  - WB_SRC_ALU/MEM/PC4/IMM constants.
  - F3_LB/LH/LW/LBU/LHU load encodings.
  - XLEN default.
- One combinational sub-module, load_align, takes (word, offset, funct3) and returns (data, misaligned). It is reused by any future load-forwarding path.

Test Plan:
- Reset: hold rst=0 with valid_mem=1 → all outputs 0. Release → first captured instruction appears the next cycle, instret still 0.
- ALU writeback: valid_mem=1, cw={1,00,0}, rd=5, alu=0x0000_1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, fwd_rd=5; following edge instret=1.
- Loads on mem_data_out=0x8180_7F01:
  - LB offset 3 → 0xFFFF_FF81.
  - LBU offset 3 → 0x0000_0081.
  - LH offset 2 → 0xFFFF_8180.
  - LHU offset 0 → 0x0000_7F01.
  - LW offset 0 → 0x8180_7F01.
- Misaligned: LW at alu=0x...02 → rf_we=0, load_misalign=1 for one cycle, instret still increments. Same case with LH at offset 1.
- Bubbles and x0:
  - stall=1 with valid_mem=1 → valid_wb=0, instret unchanged.
  - flush=1 → same result.
  - rd=0 with rf_wb=1 → valid_wb=1, rf_we=0, fwd_rd=0.
- Link and LUI, plus counter wrap:
  - wb_src=10, pc_plus_4=0x0000_0104 → rf_wdata=0x104.
  - wb_src=11, imm=0xABCD_E000 → rf_wdata=0xABCD_E000.
  - Preload instret to all-ones (force) and retire one instruction → instret=0.
